// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with occupancy count, programmable almost flags,
// sticky error flags, synchronous flush and selectable first-word-fall-through read.
module sync_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned AF_LEVEL   = 3,
  parameter int unsigned AE_LEVEL   = 1,
  parameter int unsigned FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_flush,
  input  logic                  i_clr_err,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_pop_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DepthC = (ADDR_WIDTH + 1)'(Depth);
  localparam logic [ADDR_WIDTH:0] AfC    = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AeC    = (ADDR_WIDTH + 1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] OneC   = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [Depth];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  pop_ok, push_ok, wr_en, rd_en;

  // Flags decode the count register only, so no input-to-flag path exists.
  assign o_full         = (count_q == DepthC);
  assign o_empty        = (count_q == '0);
  assign o_almost_full  = (count_q >= AfC);
  assign o_almost_empty = (count_q <= AeC);
  assign o_count        = count_q;
  assign o_overflow     = ovf_q;
  assign o_underflow    = udf_q;
  assign o_pop_data     = data_q;

  assign pop_ok  = i_pop & ~o_empty;
  assign push_ok = i_push & (~o_full | pop_ok);
  assign wr_en   = push_ok & ~i_flush;
  assign rd_en   = pop_ok & ~i_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(wr_en);
    rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(rd_en);
    count_d  = count_q;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + OneC;
      2'b01:   count_d = count_q - OneC;
      default: count_d = count_q;
    endcase
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    ovf_d = i_clr_err ? 1'b0 : ovf_q;
    udf_d = i_clr_err ? 1'b0 : udf_q;
    if (i_push && !push_ok && !i_flush) ovf_d = 1'b1;
    if (i_pop && !pop_ok && !i_flush)   udf_d = 1'b1;

    data_d = data_q;
    if (FWFT == 0) begin
      if (rd_en) data_d = mem[rd_ptr_q];
    end else if (i_flush) begin
      data_d = '0;
    end else if (count_d != '0) begin
      // The new head is the word being written when nothing older remains.
      if (wr_en && (count_q == '0 || (count_q == OneC && rd_en))) begin
        data_d = i_push_data;
      end else begin
        data_d = mem[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= i_push_data;
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: a registered-read and an FWFT instance share stimulus.
module tb_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_flush = 1'b0, i_clr_err = 1'b0, i_push = 1'b0, i_pop = 1'b0;
  logic [7:0] i_push_data = 8'h00;

  logic [7:0] d0_data, d1_data;
  logic [2:0] d0_count, d1_count;
  logic       d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_udf;
  logic       d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_udf;

  int checks = 0;
  int failures = 0;
  logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) dut0 (
    .clk(clk), .reset(reset), .i_flush(i_flush), .i_clr_err(i_clr_err), .i_push(i_push),
    .i_push_data(i_push_data), .i_pop(i_pop), .o_pop_data(d0_data), .o_full(d0_full),
    .o_empty(d0_empty), .o_almost_full(d0_af), .o_almost_empty(d0_ae), .o_count(d0_count),
    .o_overflow(d0_ovf), .o_underflow(d0_udf)
  );

  sync_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) dut1 (
    .clk(clk), .reset(reset), .i_flush(i_flush), .i_clr_err(i_clr_err), .i_push(i_push),
    .i_push_data(i_push_data), .i_pop(i_pop), .o_pop_data(d1_data), .o_full(d1_full),
    .o_empty(d1_empty), .o_almost_full(d1_af), .o_almost_empty(d1_ae), .o_count(d1_count),
    .o_overflow(d1_ovf), .o_underflow(d1_udf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_flush = 0; i_clr_err = 0; i_push = 0; i_pop = 0; i_push_data = 8'h00;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic push1(input logic [7:0] d);
    i_push = 1; i_push_data = d; step(); i_push = 0;
  endtask

  task automatic pop1();
    i_pop = 1; step(); i_pop = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (d0_data !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", d0_data); end
    checks++; if (d0_count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", d0_count); end
    checks++; if ({d0_empty, d0_full, d0_ae, d0_af} !== 4'b1010) begin
      failures++; $display("FAIL rst_flags got=%b exp=1010", {d0_empty, d0_full, d0_ae, d0_af}); end
    checks++; if ({d0_ovf, d0_udf} !== 2'b00) begin failures++; $display("FAIL rst_err got=%b exp=00", {d0_ovf, d0_udf}); end
    checks++; if ({d1_empty, d1_data} !== {1'b1, 8'h00}) begin
      failures++; $display("FAIL rst_fwft got=%b/%h exp=1/00", d1_empty, d1_data); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      push1(vals[k-1]);
      checks++; if (d0_count !== 3'(k)) begin failures++; $display("FAIL fill_count%0d got=%0d exp=%0d", k, d0_count, k); end
      checks++; if ({d0_af, d0_full, d0_ae} !== {k >= 3, k == 4, k <= 1}) begin
        failures++; $display("FAIL fill_flags%0d got=%b exp=%b", k, {d0_af, d0_full, d0_ae}, {k >= 3, k == 4, k <= 1}); end
    end
    for (int j = 1; j <= 4; j++) begin
      pop1();
      checks++; if (d0_data !== vals[j-1]) begin failures++; $display("FAIL drain_data%0d got=%h exp=%h", j, d0_data, vals[j-1]); end
      checks++; if ({d0_count, d0_empty, d0_ae} !== {3'(4 - j), j == 4, (4 - j) <= 1}) begin
        failures++; $display("FAIL drain_state%0d got=%b exp=%b", j, {d0_count, d0_empty, d0_ae}, {3'(4 - j), j == 4, (4 - j) <= 1}); end
    end
  endtask

  task automatic test_errors();
    do_reset();
    for (int k = 0; k < 4; k++) push1(vals[k]);
    push1(8'h99);
    checks++; if ({d0_count, d0_ovf} !== {3'd4, 1'b1}) begin
      failures++; $display("FAIL ovf got=%0d/%b exp=4/1", d0_count, d0_ovf); end
    for (int k = 0; k < 4; k++) pop1();
    checks++; if (d0_data !== 8'h44) begin failures++; $display("FAIL ovf_lastword got=%h exp=44", d0_data); end
    pop1();
    checks++; if ({d0_count, d0_udf, d0_data} !== {3'd0, 1'b1, 8'h44}) begin
      failures++; $display("FAIL udf got=%0d/%b/%h exp=0/1/44", d0_count, d0_udf, d0_data); end
    i_clr_err = 1; step(); i_clr_err = 0;
    checks++; if ({d0_ovf, d0_udf} !== 2'b00) begin failures++; $display("FAIL clr_err got=%b exp=00", {d0_ovf, d0_udf}); end
    i_clr_err = 1; i_pop = 1; step(); i_clr_err = 0; i_pop = 0;
    checks++; if ({d0_ovf, d0_udf} !== 2'b01) begin failures++; $display("FAIL set_wins got=%b exp=01", {d0_ovf, d0_udf}); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_seq [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
    do_reset();
    for (int k = 0; k < 4; k++) push1(vals[k]);
    i_push = 1; i_push_data = 8'h55; i_pop = 1; step(); i_push = 0; i_pop = 0;
    checks++; if ({d0_count, d0_full, d0_ovf, d0_data} !== {3'd4, 1'b1, 1'b0, 8'h11}) begin
      failures++; $display("FAIL full_pushpop got=%0d/%b/%b/%h exp=4/1/0/11", d0_count, d0_full, d0_ovf, d0_data); end
    for (int j = 0; j < 4; j++) begin
      pop1();
      checks++; if (d0_data !== exp_seq[j]) begin failures++; $display("FAIL full_seq%0d got=%h exp=%h", j, d0_data, exp_seq[j]); end
    end
    i_push = 1; i_push_data = 8'hAA; i_pop = 1; step(); i_push = 0; i_pop = 0;
    checks++; if ({d0_count, d0_udf, d0_data} !== {3'd1, 1'b1, 8'h55}) begin
      failures++; $display("FAIL empty_pushpop got=%0d/%b/%h exp=1/1/55", d0_count, d0_udf, d0_data); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      push1(8'(8'h30 + i));
      checks++; if (d0_count !== 3'd1) begin failures++; $display("FAIL wrap_count%0d got=%0d exp=1", i, d0_count); end
      pop1();
      checks++; if ({d0_count, d0_data} !== {3'd0, 8'(8'h30 + i)}) begin
        failures++; $display("FAIL wrap_data%0d got=%0d/%h exp=0/%h", i, d0_count, d0_data, 8'(8'h30 + i)); end
    end
  endtask

  task automatic test_fwft();
    do_reset();
    push1(8'h5A);
    checks++; if ({d1_empty, d1_count, d1_data} !== {1'b0, 3'd1, 8'h5A}) begin
      failures++; $display("FAIL fwft_first got=%b/%0d/%h exp=0/1/5a", d1_empty, d1_count, d1_data); end
    step();
    checks++; if (d1_data !== 8'h5A) begin failures++; $display("FAIL fwft_hold got=%h exp=5a", d1_data); end
    i_push = 1; i_push_data = 8'h6B; i_pop = 1; step(); i_push = 0; i_pop = 0;
    checks++; if ({d1_count, d1_data} !== {3'd1, 8'h6B}) begin
      failures++; $display("FAIL fwft_pushpop got=%0d/%h exp=1/6b", d1_count, d1_data); end
    push1(8'h7C);
    checks++; if ({d1_count, d1_data} !== {3'd2, 8'h6B}) begin
      failures++; $display("FAIL fwft_second got=%0d/%h exp=2/6b", d1_count, d1_data); end
    pop1();
    checks++; if (d1_data !== 8'h7C) begin failures++; $display("FAIL fwft_advance got=%h exp=7c", d1_data); end
    pop1();
    checks++; if ({d1_empty, d1_data} !== {1'b1, 8'h7C}) begin
      failures++; $display("FAIL fwft_empty got=%b/%h exp=1/7c", d1_empty, d1_data); end
  endtask

  task automatic test_flush_reset();
    do_reset();
    for (int k = 0; k < 4; k++) push1(vals[k]);
    pop1();
    checks++; if ({d0_count, d0_data, d1_data} !== {3'd3, 8'h11, 8'h22}) begin
      failures++; $display("FAIL pre_flush got=%0d/%h/%h exp=3/11/22", d0_count, d0_data, d1_data); end
    i_flush = 1; i_push = 1; i_push_data = 8'h77; step(); i_flush = 0; i_push = 0;
    checks++; if ({d0_count, d0_empty, d0_ovf} !== {3'd0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL flush got=%0d/%b/%b exp=0/1/0", d0_count, d0_empty, d0_ovf); end
    checks++; if ({d0_data, d1_data} !== {8'h11, 8'h00}) begin
      failures++; $display("FAIL flush_data got=%h/%h exp=11/00", d0_data, d1_data); end
    push1(8'h01);
    push1(8'h02);
    checks++; if ({d0_count, d1_data} !== {3'd2, 8'h01}) begin
      failures++; $display("FAIL refill got=%0d/%h exp=2/01", d0_count, d1_data); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({d0_count, d0_empty, d0_ae, d0_full, d0_af, d0_data, d1_data} !== {3'd0, 4'b1100, 8'h00, 8'h00}) begin
      failures++; $display("FAIL async_reset got=%0d/%b/%h/%h exp=0/1100/00/00", d0_count,
                           {d0_empty, d0_ae, d0_full, d0_af}, d0_data, d1_data); end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_errors();
    test_simultaneous();
    test_wrap();
    test_fwft();
    test_flush_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
